// File: rtl/id_stage_hs.sv
// Decode stage for the 16-bit MIPS-style pipeline: decodes one instruction per cycle,
// resolves BZ, and loads a valid/ready-handshaked ID/EX register with load-use interlock.
module id_stage_hs #(
  parameter int DATA_W     = 16,
  parameter int IMM_SIGNED = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        rs1_addr,
  output logic [2:0]        rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              flush,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_offset,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [2:0]        ex_alu_cmd,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [2:0]        ex_dest,
  output logic              ex_mem_we,
  output logic              ex_wb_sel,
  output logic              ex_wb_en,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU8 = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ST   = 4'd11;
  localparam logic [3:0] OP_BZ   = 4'd12;

  typedef struct packed {
    logic              valid;
    logic              illegal;
    logic [2:0]        alu_cmd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] store_data;
    logic [2:0]        dest;
    logic              mem_we;
    logic              wb_sel;
    logic              wb_en;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d, decoded;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [3:0]        opcode;
  logic [3:0]        opcode_m1;
  logic [2:0]        rs1_sel, rs2_sel;
  logic              is_alu, is_imm, is_illegal, reads_rs1, reads_rs2;
  logic              advance, hazard, accept;
  logic [DATA_W-1:0] imm_sext, imm_zext, imm_ext;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    opcode     = instr[15:12];
    opcode_m1  = opcode - 4'd1;
    rs1_sel    = instr[8:6];
    rs2_sel    = (opcode == OP_ST) ? instr[11:9] : instr[5:3];
    is_alu     = (opcode != OP_NOP) && (opcode <= OP_ALU8);
    is_imm     = (opcode >= OP_ADDI) && (opcode <= OP_ST);
    is_illegal = (opcode > OP_BZ);
    reads_rs1  = (opcode != OP_NOP) && (opcode <= OP_BZ);
    reads_rs2  = is_alu || (opcode == OP_ST);

    imm_sext = {{(DATA_W-6){instr[5]}}, instr[5:0]};
    imm_zext = {{(DATA_W-6){1'b0}}, instr[5:0]};
    imm_ext  = (IMM_SIGNED != 0) ? imm_sext : imm_zext;

    // Only a load in EX can create a hazard; ALU results are assumed forwarded.
    advance = !ex_q.valid || ex_ready;
    hazard  = ex_q.valid && ex_q.wb_sel && in_valid &&
              ((reads_rs1 && (ex_q.dest == rs1_sel)) ||
               (reads_rs2 && (ex_q.dest == rs2_sel)));
    in_ready = advance && !hazard;
    accept   = in_valid && in_ready && !flush;

    decoded = '0;
    if (is_alu) begin
      decoded.valid   = 1'b1;
      decoded.alu_cmd = opcode_m1[2:0];
      decoded.op_a    = rs1_data;
      decoded.op_b    = rs2_data;
      decoded.dest    = instr[11:9];
      decoded.wb_en   = 1'b1;
    end else if (is_imm) begin
      decoded.valid = 1'b1;
      decoded.op_a  = rs1_data;
      decoded.op_b  = imm_ext;
      if (opcode == OP_ST) begin
        decoded.store_data = rs2_data;
        decoded.mem_we     = 1'b1;
      end else begin
        decoded.dest   = instr[11:9];
        decoded.wb_en  = 1'b1;
        decoded.wb_sel = (opcode == OP_LD);
      end
    end else if (is_illegal) begin
      decoded.illegal = 1'b1;
    end

    if (flush) begin
      ex_d = '0;
    end else if (advance) begin
      ex_d = accept ? decoded : '0;
    end else begin
      ex_d = ex_q;
    end

    stall_cnt_d = stall_cnt_q;
    if (hazard && advance && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rs1_addr      = rs1_sel;
  assign rs2_addr      = rs2_sel;
  assign branch_taken  = accept && (opcode == OP_BZ) && (rs1_data == '0);
  assign branch_offset = imm_sext;

  assign ex_valid      = ex_q.valid;
  assign ex_illegal    = ex_q.illegal;
  assign ex_alu_cmd    = ex_q.alu_cmd;
  assign ex_op_a       = ex_q.op_a;
  assign ex_op_b       = ex_q.op_b;
  assign ex_store_data = ex_q.store_data;
  assign ex_dest       = ex_q.dest;
  assign ex_mem_we     = ex_q.mem_we;
  assign ex_wb_sel     = ex_q.wb_sel;
  assign ex_wb_en      = ex_q.wb_en;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: a signed-immediate instance with a wide stall counter
// and a zero-extending instance with a 2-bit counter share the same stimulus.
module tb_id_stage_hs;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, ex_ready;
  logic [15:0] instr;
  logic [15:0] rs1_data, rs2_data;

  logic        in_ready, branch_taken, ex_valid, ex_mem_we, ex_wb_sel, ex_wb_en, ex_illegal;
  logic [2:0]  rs1_addr, rs2_addr, ex_alu_cmd, ex_dest;
  logic [15:0] branch_offset, ex_op_a, ex_op_b, ex_store_data, stall_cnt;

  logic        u_in_ready, u_branch_taken, u_ex_valid, u_ex_mem_we, u_ex_wb_sel, u_ex_wb_en;
  logic        u_ex_illegal;
  logic [2:0]  u_rs1_addr, u_rs2_addr, u_ex_alu_cmd, u_ex_dest;
  logic [15:0] u_branch_offset, u_ex_op_a, u_ex_op_b, u_ex_store_data;
  logic [1:0]  u_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_stage_hs #(.DATA_W(16), .IMM_SIGNED(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_cmd(ex_alu_cmd), .ex_op_a(ex_op_a),
    .ex_op_b(ex_op_b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_mem_we(ex_mem_we), .ex_wb_sel(ex_wb_sel), .ex_wb_en(ex_wb_en),
    .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
  );

  id_stage_hs #(.DATA_W(16), .IMM_SIGNED(0), .CNT_W(2)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .instr(instr),
    .rs1_addr(u_rs1_addr), .rs2_addr(u_rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .branch_taken(u_branch_taken), .branch_offset(u_branch_offset),
    .ex_valid(u_ex_valid), .ex_ready(ex_ready), .ex_alu_cmd(u_ex_alu_cmd),
    .ex_op_a(u_ex_op_a), .ex_op_b(u_ex_op_b), .ex_store_data(u_ex_store_data),
    .ex_dest(u_ex_dest), .ex_mem_we(u_ex_mem_we), .ex_wb_sel(u_ex_wb_sel),
    .ex_wb_en(u_ex_wb_en), .ex_illegal(u_ex_illegal), .stall_cnt(u_stall_cnt)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    instr = 16'h0000; rs1_data = 16'h0; rs2_data = 16'h0;
    step(); step();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset ex_valid got %0h want 0", ex_valid); end
    vectors++; if (ex_illegal !== 1'b0) begin miscompares++; $display("FAIL reset ex_illegal got %0h want 0", ex_illegal); end
    vectors++; if ({ex_op_a, ex_op_b, ex_store_data} !== 48'h0) begin miscompares++; $display("FAIL reset ex_data got %h want 0", {ex_op_a, ex_op_b, ex_store_data}); end
    vectors++; if ({ex_alu_cmd, ex_dest, ex_mem_we, ex_wb_sel, ex_wb_en} !== 9'h0) begin miscompares++; $display("FAIL reset ex_ctrl got %h want 0", {ex_alu_cmd, ex_dest, ex_mem_we, ex_wb_sel, ex_wb_en}); end
    vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset stall_cnt got %0d want 0", stall_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %0h want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    in_valid = 1'b1; instr = 16'h3298; rs1_data = 16'd5; rs2_data = 16'd7;
    #1;
    vectors++; if ({rs1_addr, rs2_addr} !== {3'd2, 3'd3}) begin miscompares++; $display("FAIL alu rs_addr got %0d/%0d want 2/3", rs1_addr, rs2_addr); end
    step();
    vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL alu ex_valid got %0h want 1", ex_valid); end
    vectors++; if (ex_alu_cmd !== 3'd2) begin miscompares++; $display("FAIL alu alu_cmd got %0d want 2", ex_alu_cmd); end
    vectors++; if ({ex_op_a, ex_op_b} !== {16'd5, 16'd7}) begin miscompares++; $display("FAIL alu operands got %0d/%0d want 5/7", ex_op_a, ex_op_b); end
    vectors++; if ({ex_dest, ex_wb_en, ex_wb_sel, ex_mem_we} !== {3'd1, 3'b100}) begin miscompares++; $display("FAIL alu dest/ctl got %0d %b%b%b want 1 100", ex_dest, ex_wb_en, ex_wb_sel, ex_mem_we); end
    idle();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL alu drain ex_valid got %0h want 0", ex_valid); end
  endtask

  task automatic test_imm_store();
    in_valid = 1'b1; instr = 16'h927F; rs1_data = 16'd10; rs2_data = 16'h0;
    step();
    vectors++; if (ex_op_b !== 16'hFFFF) begin miscompares++; $display("FAIL addi signed op_b got %h want ffff", ex_op_b); end
    vectors++; if (u_ex_op_b !== 16'h003F) begin miscompares++; $display("FAIL addi unsigned op_b got %h want 003f", u_ex_op_b); end
    vectors++; if ({ex_valid, ex_alu_cmd, ex_dest, ex_wb_en} !== {1'b1, 3'd0, 3'd1, 1'b1}) begin miscompares++; $display("FAIL addi ctl got v%b cmd%0d d%0d we%b want v1 cmd0 d1 we1", ex_valid, ex_alu_cmd, ex_dest, ex_wb_en); end
    instr = 16'hBAC4; rs1_data = 16'h1000; rs2_data = 16'h00AB;
    #1;
    vectors++; if ({rs1_addr, rs2_addr} !== {3'd3, 3'd5}) begin miscompares++; $display("FAIL st rs_addr got %0d/%0d want 3/5", rs1_addr, rs2_addr); end
    step();
    vectors++; if ({ex_mem_we, ex_wb_en, ex_wb_sel} !== 3'b100) begin miscompares++; $display("FAIL st ctl got %b want 100", {ex_mem_we, ex_wb_en, ex_wb_sel}); end
    vectors++; if (ex_store_data !== 16'h00AB) begin miscompares++; $display("FAIL st store_data got %h want 00ab", ex_store_data); end
    vectors++; if ({ex_op_b, ex_dest} !== {16'h0004, 3'd0}) begin miscompares++; $display("FAIL st op_b/dest got %h/%0d want 0004/0", ex_op_b, ex_dest); end
    idle();
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; instr = 16'hA443; rs1_data = 16'd1; rs2_data = 16'd0;
    step();
    vectors++; if ({ex_valid, ex_wb_sel, ex_wb_en, ex_dest} !== {3'b111, 3'd2}) begin miscompares++; $display("FAIL ld ctl got %b%b%b d%0d want 111 d2", ex_valid, ex_wb_sel, ex_wb_en, ex_dest); end
    instr = 16'h16A0; rs1_data = 16'd9; rs2_data = 16'd4;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL load_use hazard in_ready got %0h want 0", in_ready); end
    step();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL load_use bubble ex_valid got %0h want 0", ex_valid); end
    vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL load_use stall_cnt got %0d want 1", stall_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL load_use retry in_ready got %0h want 1", in_ready); end
    step();
    vectors++; if ({ex_valid, ex_alu_cmd, ex_dest} !== {1'b1, 3'd0, 3'd3}) begin miscompares++; $display("FAIL load_use dep got v%b cmd%0d d%0d want v1 cmd0 d3", ex_valid, ex_alu_cmd, ex_dest); end
    vectors++; if ({ex_op_a, ex_op_b} !== {16'd9, 16'd4}) begin miscompares++; $display("FAIL load_use dep operands got %0d/%0d want 9/4", ex_op_a, ex_op_b); end
    idle();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; instr = 16'h3298; rs1_data = 16'd5; rs2_data = 16'd7;
    step();
    ex_ready = 1'b0; instr = 16'h2850; rs1_data = 16'd1; rs2_data = 16'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL backpressure in_ready cycle %0d got %0h want 0", i, in_ready); end
      step();
      vectors++; if ({ex_valid, ex_alu_cmd, ex_op_a, ex_op_b, ex_dest} !== {1'b1, 3'd2, 16'd5, 16'd7, 3'd1}) begin miscompares++; $display("FAIL backpressure hold cycle %0d got v%b cmd%0d a%0d b%0d d%0d want v1 cmd2 a5 b7 d1", i, ex_valid, ex_alu_cmd, ex_op_a, ex_op_b, ex_dest); end
    end
    ex_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL backpressure release in_ready got %0h want 1", in_ready); end
    step();
    vectors++; if ({ex_valid, ex_alu_cmd, ex_op_a, ex_op_b, ex_dest} !== {1'b1, 3'd1, 16'd1, 16'd2, 3'd4}) begin miscompares++; $display("FAIL backpressure next got v%b cmd%0d a%0d b%0d d%0d want v1 cmd1 a1 b2 d4", ex_valid, ex_alu_cmd, ex_op_a, ex_op_b, ex_dest); end
    vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL backpressure stall_cnt got %0d want 1", stall_cnt); end
    idle();
  endtask

  task automatic test_branch();
    in_valid = 1'b1; instr = 16'hC07E; rs1_data = 16'd0; rs2_data = 16'd0;
    #1;
    vectors++; if (branch_taken !== 1'b1) begin miscompares++; $display("FAIL bz taken got %0h want 1", branch_taken); end
    vectors++; if ({branch_offset, u_branch_offset} !== {16'hFFFE, 16'hFFFE}) begin miscompares++; $display("FAIL bz offset got %h/%h want fffe/fffe", branch_offset, u_branch_offset); end
    step();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL bz issued ex_valid got %0h want 0", ex_valid); end
    rs1_data = 16'd1;
    #1;
    vectors++; if (branch_taken !== 1'b0) begin miscompares++; $display("FAIL bz nonzero taken got %0h want 0", branch_taken); end
    rs1_data = 16'd0; flush = 1'b1;
    #1;
    vectors++; if ({branch_taken, in_ready} !== 2'b01) begin miscompares++; $display("FAIL bz flush taken/in_ready got %b%b want 01", branch_taken, in_ready); end
    step();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL bz flush ex_valid got %0h want 0", ex_valid); end
    flush = 1'b0; instr = 16'h3298; rs1_data = 16'd5; rs2_data = 16'd7;
    step();
    ex_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
    step();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stalled ex_valid got %0h want 0", ex_valid); end
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; instr = 16'hE000;
    step();
    vectors++; if ({ex_illegal, ex_valid, ex_wb_en, ex_mem_we} !== 4'b1000) begin miscompares++; $display("FAIL illegal got ill%b v%b we%b mw%b want ill1 v0 we0 mw0", ex_illegal, ex_valid, ex_wb_en, ex_mem_we); end
    idle();
    vectors++; if (ex_illegal !== 1'b0) begin miscompares++; $display("FAIL illegal clear got %0h want 0", ex_illegal); end
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; instr = 16'h3298; rs1_data = 16'd5; rs2_data = 16'd7;
    step();
    ex_ready = 1'b0; in_valid = 1'b0;
    step();
    vectors++; if ({ex_valid, stall_cnt} !== {1'b1, 16'd1}) begin miscompares++; $display("FAIL pre_reset v/cnt got %b/%0d want 1/1", ex_valid, stall_cnt); end
    rst = 1'b1;
    step();
    vectors++; if ({ex_valid, ex_alu_cmd, ex_op_a, ex_op_b, ex_dest, ex_wb_en} !== 42'h0) begin miscompares++; $display("FAIL reset_stall ex got v%b cmd%0d a%0d b%0d d%0d we%b want 0", ex_valid, ex_alu_cmd, ex_op_a, ex_op_b, ex_dest, ex_wb_en); end
    vectors++; if ({stall_cnt, u_stall_cnt} !== 18'h0) begin miscompares++; $display("FAIL reset_stall stall_cnt got %0d/%0d want 0/0", stall_cnt, u_stall_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_stall in_ready got %0h want 1", in_ready); end
    rst = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic test_stall_saturate();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = 16'hA443; rs1_data = 16'd1; rs2_data = 16'd0;
      step();
      instr = 16'h16A0; rs1_data = 16'd9; rs2_data = 16'd4;
      step();
      step();
    end
    idle();
    vectors++; if (stall_cnt !== 16'd4) begin miscompares++; $display("FAIL saturate wide stall_cnt got %0d want 4", stall_cnt); end
    vectors++; if (u_stall_cnt !== 2'd3) begin miscompares++; $display("FAIL saturate narrow stall_cnt got %0d want 3", u_stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_imm_store();
    test_load_use();
    test_backpressure();
    test_branch();
    test_illegal();
    test_reset_mid_stall();
    test_stall_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_stage_hs.md
# id_stage_hs

Parametrised decode stage for the 16-bit MIPS-style pipeline, successor to the fixed-width ID stage. Decodes one 16-bit instruction per cycle, reads operands from the register file, and resolves BZ. Loads a valid/ready-handshaked ID/EX pipeline register, with load-use interlock, external flush and a saturating stall counter. Sits between IF (upstream handshake) and EX (downstream handshake).

## Interface
- DATA_W, 16: datapath width (≥ 8); operands, immediates, store data.
- IMM_SIGNED, 1: 1 = sign-extend instr[5:0] to DATA_W; 0 = zero-extend.
- CNT_W, 16: stall counter width.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  IF presents instruction.
- in_ready  out  1  ID accepts instruction this cycle.
- instr  in  16  instruction word.
- rs1_addr, rs2_addr  out  3  register-file read addresses (combinational).
- rs1_data, rs2_data  in  DATA_W  register-file read data (same cycle).
- flush  in  1  discard ID/EX contents and incoming instruction.
- branch_taken  out  1  BZ accepted and rs1_data == 0 (combinational).
- branch_offset  out  DATA_W  instr[5:0] sign-extended (always signed).
- ex_valid  out  1  ID/EX register holds an operation.
- ex_ready  in  1  EX consumes this cycle.
- ex_alu_cmd  out  3; ex_op_a, ex_op_b, ex_store_data  out  DATA_W; ex_dest  out  3; ex_mem_we, ex_wb_sel, ex_wb_en  out  1 each.
- ex_illegal  out  1  registered: accepted opcode was 13–15.
- stall_cnt  out  CNT_W  saturating count of interlock bubble cycles.

## Operation
- Fields: opcode = instr[15:12], dest = instr[11:9], rs1 = instr[8:6], rs2 = instr[5:3], imm = instr[5:0].
- rs1_addr = rs1; rs2_addr = instr[11:9] when opcode = ST (11), else rs2.
- Opcode 0 NOP: nothing issued (bubble).
- Opcodes 1–8 ALU: alu_cmd = opcode−1, op_a = rs1_data, op_b = rs2_data, wb_en = 1, dest.
- Opcode 9 ADDI: alu_cmd = 0, op_b = ext(imm), wb_en = 1, dest.
- Opcode 10 LD: alu_cmd = 0, op_b = ext(imm), wb_en = 1, wb_sel = 1, dest.
- Opcode 11 ST: alu_cmd = 0, op_b = ext(imm), mem_we = 1, store_data = rs2_data, wb_en = 0.
- Opcode 12 BZ: never issued to EX; branch_taken = accept && rs1_data == 0.
- Opcodes 13–15: issued as a bubble with ex_illegal = 1 and all enables 0.
- Fields not listed for an opcode are loaded as 0.
- Handshake:
  - advance = !ex_valid || ex_ready.
  - hazard = ex_valid && ex_wb_sel && in_valid && ex_dest is read by instr. rs1 is read by opcodes 1–12; rs2/instr[11:9] is read by opcodes 1–8 and 11.
  - in_ready = advance && !hazard. accept = in_valid && in_ready && !flush.
- Register update, priority rst > flush > advance:
  - flush: ex_valid ← 0, ex_illegal ← 0, instr dropped, branch_taken = 0.
  - advance && accept && issuing opcode: load fields, ex_valid ← 1.
  - advance otherwise (no input, hazard, NOP, BZ, illegal): ex_valid ← 0, all enables ← 0.
  - !advance: hold every ex_* output unchanged.
- stall_cnt: +1 each cycle hazard && advance && !flush; saturates at 2^CNT_W−1; cleared only by rst.

## Timing
- Decode-to-EX latency: 1 cycle. branch_taken and rs*_addr: 0 cycles.
- Load-use costs exactly one bubble: the hazard cycle loads ex_valid = 0. The next cycle the LD has left, and the dependent instruction is accepted.
- Reset: all ex_* outputs 0, ex_valid 0, ex_illegal 0, stall_cnt 0. in_ready = 1 during and after reset when no flush.
- Reset mid-stall: the held operation is lost.
- Flush while the downstream is stalled (ex_valid && !ex_ready) still clears ex_valid.
- in_ready must not depend on flush.

## Test plan
- ALU: instr 0x3298 (op 3, dest 1, rs1 2, rs2 3), rs1_data 5, rs2_data 7 -> next cycle ex_valid 1, alu_cmd 2, op_a 5, op_b 7, dest 1, wb_en 1.
- ADDI/ST imm sign: ADDI instr 0x927F, rs1_data 10, IMM_SIGNED=1 -> op_b 0xFFFF. With IMM_SIGNED=0 -> op_b 0x003F. ST -> mem_we 1, store_data = rs2_data, wb_en 0.
- Load-use: LD dest 2, then ALU reading rs1 = 2 -> in_ready 0 for one cycle, one bubble (ex_valid 0), stall_cnt 1, then dependent issues.
- Backpressure: ex_ready 0 for 3 cycles with ex_valid 1 -> ex_* stable, in_ready 0. ex_ready 1 -> next instruction loads.
- BZ: rs1_data 0 -> branch_taken 1, branch_offset 0xFFFE for imm 0x3E, no EX issue. rs1_data 1 -> branch_taken 0. Flush asserted same cycle -> branch_taken 0, ex_valid 0.
- Illegal opcode 0xE000 -> ex_illegal 1, ex_valid 0. rst asserted mid-stall -> all outputs 0 next cycle, stall_cnt 0.
